// File: rtl/regfile_read_arbiter_pkg.sv
// Shared definitions for the register-file read arbiter.
//   - Default widths and requester count.
//   - XZR_ADDR: the architectural zero register, read as 0 when enabled.
//   - onehot_to_idx: converts a winner one-hot vector to its binary index.
package regfile_arb_pkg;

    localparam int DEFAULT_NREQ = 3;
    localparam int DEFAULT_AW   = 5;
    localparam int DEFAULT_DW   = 64;

    localparam logic [4:0] XZR_ADDR = 5'd31;

    // Widest requester vector the arbiter supports, and its index width.
    localparam int MAX_NREQ  = 8;
    localparam int MAX_IDX_W = 3;

    // Input is assumed one-hot (or zero, which maps to index 0).
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_NREQ-1:0] onehot);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (onehot[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Bus between the read arbiter, its requesters and the 32:1 read mux.
//   req_valid/req_addr/req_ready : per-requester request handshake
//   mux_sel/mux_data             : registered select out, mux data back in
//   rsp_valid/rsp_data           : one-cycle response pulse and shared data
// Modports:
//   master : requester side plus the read mux (drives requests and mux_data)
//   slave  : the arbiter
interface regfile_read_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int AW   = DEFAULT_AW,
    parameter int DW   = DEFAULT_DW
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_ready;
    logic [AW-1:0]      mux_sel;
    logic [DW-1:0]      mux_data;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;

    modport master (
        output req_valid, req_addr, mux_data,
        input  req_ready, mux_sel, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, mux_data,
        output req_ready, mux_sel, rsp_valid, rsp_data
    );

endinterface

// File: rtl/regfile_read_arbiter_rr_pick.sv
// Round-robin winner picker.
//   valid      : request vector
//   ptr        : index with highest priority this cycle
//   win_onehot : winning request, one-hot (zero when nothing valid)
//   win_idx    : binary index of the winner
//   any        : at least one request valid
module rr_pick
    import regfile_arb_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win_onehot,
    output logic [PW-1:0]   win_idx,
    output logic            any
);

    logic [2*NREQ-1:0] scan;
    logic [2*NREQ-1:0] first;

    // The request vector is laid out twice so that a plain lowest-bit search
    // starting at ptr naturally wraps: bits below ptr are masked out of the
    // low copy, and the high copy supplies the wrapped-around candidates.
    // x & -x isolates the lowest set bit; folding the two halves gives the
    // winner as a one-hot over NREQ.
    always_comb begin
        scan = {valid, valid};
        for (int i = 0; i < NREQ; i++) begin
            if (i < int'(ptr)) begin
                scan[i] = 1'b0;
            end
        end
        first      = scan & (-scan);
        win_onehot = first[NREQ-1:0] | first[2*NREQ-1:NREQ];
        win_idx    = PW'(onehot_to_idx(MAX_NREQ'(win_onehot)));
        any        = |valid;
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one registered-select 32:1 register-file read mux among NREQ
// requesters. Round-robin arbitration; requesters on the winner's address
// are granted together. Grant in cycle T, select registered at the end of T,
// mux data captured at the end of T+1, response pulse during T+2.
//   clk, reset : clock, synchronous active-high reset
//   en         : gates new grants; reads already in flight still complete
//   bus        : slave side of regfile_read_arbiter_if
module regfile_read_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NREQ     = DEFAULT_NREQ,
    parameter int AW       = DEFAULT_AW,
    parameter int DW       = DEFAULT_DW,
    parameter bit ZERO_R31 = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    regfile_read_arbiter_if.slave   bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(XZR_ADDR);

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] win_onehot;
    logic            any_valid;

    logic [AW-1:0]   win_addr;
    logic [NREQ-1:0] grant;
    logic            grant_any;

    logic            a_valid;
    logic [NREQ-1:0] a_mask;
    logic            a_zero;

    logic [AW-1:0]   mux_sel_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic [DW-1:0]   rsp_data_q;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid      (bus.req_valid),
        .ptr        (rr_ptr),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .any        (any_valid)
    );

    // Winner's address is selected with the one-hot so no index decode is
    // needed. Every valid requester on that same address rides along with
    // the winner, since one mux read serves them all.
    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_onehot[i]) begin
                win_addr = win_addr | bus.req_addr[i*AW +: AW];
            end
        end
        grant = '0;
        if (!reset && en && any_valid) begin
            for (int i = 0; i < NREQ; i++) begin
                grant[i] = bus.req_valid[i] && (bus.req_addr[i*AW +: AW] == win_addr);
            end
        end
    end

    assign grant_any     = |grant;
    assign bus.req_ready = grant;
    assign bus.mux_sel   = mux_sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    // Stage A registers the select and the grant bookkeeping; stage B
    // samples the mux a full cycle later. rsp_data only moves when a read
    // completes, so it holds between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            mux_sel_q   <= '0;
            rr_ptr      <= '0;
            a_valid     <= 1'b0;
            a_mask      <= '0;
            a_zero      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            if (grant_any) begin
                mux_sel_q <= win_addr;
                a_valid   <= 1'b1;
                a_mask    <= grant;
                a_zero    <= ZERO_R31 && (win_addr == ZERO_ADDR);
                rr_ptr    <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
            end else begin
                a_valid   <= 1'b0;
            end

            if (a_valid) begin
                rsp_valid_q <= a_mask;
                rsp_data_q  <= a_zero ? '0 : bus.mux_data;
            end else begin
                rsp_valid_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter. Two instances share the
// request stimulus: one zeroes XZR reads, the other passes mux data through.
// A behavioural model arbitrates by scanning from a pointer, merges equal
// addresses, and schedules responses in a queue two edges after each grant.
module tb_regfile_read_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 64;

    logic clk = 1'b0;
    logic reset;
    logic en;

    always #5 clk = ~clk;

    regfile_read_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus_z ();
    regfile_read_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus_nz ();

    regfile_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ZERO_R31(1'b1)) dut_z (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .bus   (bus_z)
    );

    regfile_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ZERO_R31(1'b0)) dut_nz (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .bus   (bus_nz)
    );

    logic [DW-1:0] rf [32];

    assign bus_z.mux_data   = rf[bus_z.mux_sel];
    assign bus_nz.mux_data  = rf[bus_nz.mux_sel];
    assign bus_nz.req_valid = bus_z.req_valid;
    assign bus_nz.req_addr  = bus_z.req_addr;

    typedef struct {
        int              due;
        logic [NREQ-1:0] mask;
        logic [DW-1:0]   d_z;
        logic [DW-1:0]   d_nz;
    } rsp_t;

    rsp_t          exp_q [$];
    int            m_ptr;
    logic [AW-1:0] m_sel;
    logic [DW-1:0] m_data_z;
    logic [DW-1:0] m_data_nz;
    int            edge_no;
    int            tests_run;
    int            tests_failed;

    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h (edge %0d)", tag, got, want, edge_no);
        end
    endtask

    function automatic logic [NREQ*AW-1:0] pack3(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                                 input logic [AW-1:0] a2);
        return {a2, a1, a0};
    endfunction

    // Reference arbitration: first valid index walking up from m_ptr modulo
    // NREQ, then every valid requester whose address equals the winner's.
    function automatic void modelArbitrate(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a,
                                           output logic [NREQ-1:0] rdy, output int w);
        rdy = '0;
        w   = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (w < 0 && v[i]) w = i;
        end
        if (w >= 0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (v[i] && a[i*AW +: AW] == a[w*AW +: AW]) rdy[i] = 1'b1;
            end
        end
    endfunction

    // One clock cycle: drive inputs, check the combinational grant, advance
    // the model across the edge, then check the registered outputs.
    task automatic applyStimulus(input logic rst_i, input logic en_i, input logic [NREQ-1:0] v,
                                 input logic [NREQ*AW-1:0] a, output logic [NREQ-1:0] granted);
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_v;
        logic [AW-1:0]   waddr;
        int              w;
        rsp_t            e;

        reset           = rst_i;
        en              = en_i;
        bus_z.req_valid = v;
        bus_z.req_addr  = a;
        #3;
        if (rst_i || !en_i) begin
            exp_rdy = '0;
            w       = -1;
        end else begin
            modelArbitrate(v, a, exp_rdy, w);
        end
        checkOutput("req_ready", DW'(bus_z.req_ready), DW'(exp_rdy));
        checkOutput("req_ready_nz", DW'(bus_nz.req_ready), DW'(exp_rdy));

        @(posedge clk);
        #1;
        edge_no++;
        exp_v = '0;
        if (rst_i) begin
            exp_q.delete();
            m_ptr     = 0;
            m_sel     = '0;
            m_data_z  = '0;
            m_data_nz = '0;
        end else begin
            if (w >= 0) begin
                waddr = a[w*AW +: AW];
                e.due  = edge_no + 1;
                e.mask = exp_rdy;
                e.d_z  = (waddr == 5'd31) ? '0 : rf[waddr];
                e.d_nz = rf[waddr];
                exp_q.push_back(e);
                m_sel = waddr;
                m_ptr = (w + 1) % NREQ;
            end
            if (exp_q.size() > 0 && exp_q[0].due == edge_no) begin
                e         = exp_q.pop_front();
                exp_v     = e.mask;
                m_data_z  = e.d_z;
                m_data_nz = e.d_nz;
            end
        end
        checkOutput("mux_sel", DW'(bus_z.mux_sel), DW'(m_sel));
        checkOutput("rsp_valid", DW'(bus_z.rsp_valid), DW'(exp_v));
        checkOutput("rsp_data", bus_z.rsp_data, m_data_z);
        checkOutput("rsp_valid_nz", DW'(bus_nz.rsp_valid), DW'(exp_v));
        checkOutput("rsp_data_nz", bus_nz.rsp_data, m_data_nz);
        granted = exp_rdy;
    endtask

    logic [NREQ-1:0] g;
    logic [NREQ-1:0] pend;
    logic [AW-1:0]   paddr [NREQ];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        edge_no      = 0;
        m_ptr        = 0;
        m_sel        = '0;
        m_data_z     = '0;
        m_data_nz    = '0;
        reset        = 1'b1;
        en           = 1'b0;
        bus_z.req_valid = '0;
        bus_z.req_addr  = '0;
        for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
        rf[1]  = 64'h101;
        rf[2]  = 64'h102;
        rf[3]  = 64'h103;
        rf[5]  = 64'hDEAD_BEEF_0000_0005;
        rf[31] = '1;

        // Reset state
        applyStimulus(1'b1, 1'b0, 3'b000, '0, g);
        applyStimulus(1'b1, 1'b1, 3'b111, pack3(5'd1, 5'd2, 5'd3), g);
        checkOutput("reset_rsp_data", bus_z.rsp_data, 64'h0);

        // Single read
        applyStimulus(1'b0, 1'b1, 3'b001, pack3(5'd5, 5'd0, 5'd0), g);
        checkOutput("single_grant", DW'(g), 64'h1);
        checkOutput("single_mux_sel", DW'(bus_z.mux_sel), 64'd5);
        applyStimulus(1'b0, 1'b1, 3'b000, '0, g);
        checkOutput("single_rsp_valid", DW'(bus_z.rsp_valid), 64'h1);
        checkOutput("single_rsp_data", bus_z.rsp_data, 64'hDEAD_BEEF_0000_0005);
        applyStimulus(1'b0, 1'b1, 3'b000, '0, g);

        // Round robin, all held on distinct addresses
        applyStimulus(1'b1, 1'b1, 3'b000, '0, g);
        applyStimulus(1'b0, 1'b1, 3'b111, pack3(5'd1, 5'd2, 5'd3), g);
        checkOutput("rr_grant0", DW'(g), 64'h1);
        applyStimulus(1'b0, 1'b1, 3'b111, pack3(5'd1, 5'd2, 5'd3), g);
        checkOutput("rr_grant1", DW'(g), 64'h2);
        applyStimulus(1'b0, 1'b1, 3'b111, pack3(5'd1, 5'd2, 5'd3), g);
        checkOutput("rr_grant2", DW'(g), 64'h4);
        applyStimulus(1'b0, 1'b1, 3'b111, pack3(5'd1, 5'd2, 5'd3), g);
        checkOutput("rr_grant3_wrap", DW'(g), 64'h1);
        checkOutput("rr_rsp_data", bus_z.rsp_data, 64'h103);
        for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b1, 3'b000, '0, g);

        // Address merge: requesters 0 and 2 share address 7
        applyStimulus(1'b1, 1'b1, 3'b000, '0, g);
        applyStimulus(1'b0, 1'b1, 3'b111, pack3(5'd7, 5'd8, 5'd7), g);
        checkOutput("merge_grant", DW'(g), 64'h5);
        applyStimulus(1'b0, 1'b1, 3'b010, pack3(5'd7, 5'd8, 5'd7), g);
        checkOutput("merge_next_grant", DW'(g), 64'h2);
        checkOutput("merge_rsp_valid", DW'(bus_z.rsp_valid), 64'h5);
        for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b1, 3'b000, '0, g);

        // XZR read on both instances
        applyStimulus(1'b0, 1'b1, 3'b010, pack3(5'd0, 5'd31, 5'd0), g);
        applyStimulus(1'b0, 1'b1, 3'b000, '0, g);
        checkOutput("xzr_rsp_valid", DW'(bus_z.rsp_valid), 64'h2);
        checkOutput("xzr_zeroed", bus_z.rsp_data, 64'h0);
        checkOutput("xzr_passthru", bus_nz.rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(1'b0, 1'b1, 3'b000, '0, g);

        // en falls with a read in flight; pointer must not move while disabled
        applyStimulus(1'b1, 1'b1, 3'b000, '0, g);
        applyStimulus(1'b0, 1'b1, 3'b001, pack3(5'd4, 5'd2, 5'd3), g);
        applyStimulus(1'b0, 1'b0, 3'b111, pack3(5'd4, 5'd2, 5'd3), g);
        checkOutput("en_inflight_rsp", DW'(bus_z.rsp_valid), 64'h1);
        applyStimulus(1'b0, 1'b0, 3'b111, pack3(5'd4, 5'd2, 5'd3), g);
        applyStimulus(1'b0, 1'b0, 3'b111, pack3(5'd4, 5'd2, 5'd3), g);
        applyStimulus(1'b0, 1'b1, 3'b111, pack3(5'd4, 5'd2, 5'd3), g);
        checkOutput("en_ptr_held", DW'(g), 64'h2);
        for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b1, 3'b000, '0, g);

        // Reset with a read in flight
        applyStimulus(1'b0, 1'b1, 3'b001, pack3(5'd9, 5'd0, 5'd0), g);
        applyStimulus(1'b1, 1'b1, 3'b000, '0, g);
        checkOutput("rst_mux_sel", DW'(bus_z.mux_sel), 64'h0);
        applyStimulus(1'b0, 1'b1, 3'b111, pack3(5'd1, 5'd2, 5'd3), g);
        checkOutput("rst_no_rsp", DW'(bus_z.rsp_valid), 64'h0);
        checkOutput("rst_ptr_zero", DW'(g), 64'h1);
        for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b1, 3'b000, '0, g);

        // Randomized traffic; requesters hold until granted
        pend = '0;
        for (int i = 0; i < NREQ; i++) paddr[i] = '0;
        for (int c = 0; c < 400; c++) begin
            logic               r_rst;
            logic               r_en;
            logic [NREQ*AW-1:0] av;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i]  = 1'b1;
                    paddr[i] = ($urandom_range(3, 0) == 0) ? 5'd31 : AW'($urandom_range(6, 0));
                end
                av[i*AW +: AW] = paddr[i];
            end
            r_rst = ($urandom_range(99, 0) == 0);
            r_en  = ($urandom_range(9, 0) != 0);
            applyStimulus(r_rst, r_en, pend, av, g);
            pend = pend & ~g;
        end
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 3'b000, '0, g);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_read_arbiter.md
Name: regfile_read_arbiter

Overview:
- Shares one 64-bit, 32:1 register-file read multiplexer among NREQ requesters, e.g. ID-stage Rn, ID-stage Rm and a debug/scan port.
- Arbitrates round-robin and drives the mux select from a register.
- Captures the mux output after one full settle cycle and returns it to every granted requester.
- Fully pipelined: accepts one grant per cycle, with a fixed 2-cycle grant-to-response latency.

Parameters:
NREQ, 3, number of requesters (2..8)
AW, 5, register address width
DW, 64, data width
ZERO_R31, 1, if 1 then address 31 (XZR) returns 0 regardless of mux data

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
en  in  1  when 0, no new grants; in-flight reads still complete
req_valid  in  NREQ  per-requester read request
req_addr  in  NREQ*AW  per-requester register address; slice i = [i*AW +: AW]
req_ready  out  NREQ  combinational grant; handshake completes when req_valid[i] && req_ready[i]
mux_sel  out  AW  registered select to the 32:1 read mux
mux_data  in  DW  read-mux output, valid by the end of the cycle after mux_sel changes
rsp_valid  out  NREQ  one-cycle response pulse per granted requester
rsp_data  out  DW  registered response data, shared by all rsp_valid bits

Behaviour:
- Reset values, applied on the first clk edge with reset=1:
  - mux_sel=0, rsp_valid=0, rsp_data=0, rr_ptr=0, both pipeline valid bits cleared.
  - req_ready is 0 while reset=1.
- Arbitration, cycle T (combinational):
  - Only when en=1 and reset=0.
  - Scan req_valid starting at index rr_ptr, wrapping modulo NREQ. The first valid index is the winner W.
  - req_ready[i]=1 for W and for every other valid i with req_addr[i]==req_addr[W] (address merge). All other bits are 0.
  - No valid requests, or en=0: req_ready=0.
- Stage A, edge ending T:
  - If any grant: mux_sel<=req_addr[W]; a_valid<=1; a_mask<=req_ready; a_zero<=(ZERO_R31 && req_addr[W]==31); rr_ptr<=(W+1) mod NREQ.
  - Else: a_valid<=0; mux_sel and rr_ptr hold.
- Stage B, edge ending T+1: mux_data has had a full cycle to settle on mux_sel.
  - rsp_data<=a_zero ? 0 : mux_data.
  - rsp_valid<=a_valid ? a_mask : 0.
- Timing:
  - Response is visible during cycle T+2, for exactly one cycle.
  - rsp_data holds its value when rsp_valid=0.
  - There is no response backpressure; requesters must sample rsp_data at their rsp_valid pulse.
- Request rules:
  - Requesters hold req_valid/req_addr stable until req_ready.
  - A requester may re-request in the cycle after its grant.
  - Back-to-back grants: new mux_sel each cycle, responses in consecutive cycles, in grant order.
- Fairness: with all NREQ valid on distinct addresses, every requester is served within NREQ consecutive enabled cycles.
- Boundary conditions:
  - NREQ not a power of 2: rr_ptr wraps from NREQ-1 to 0.
  - en falls with a read in flight: the response still arrives at T+2.
  - en=0 does not alter rr_ptr.
  - reset mid-operation: in-flight reads are discarded, no rsp_valid is produced after reset, and rr_ptr returns to 0.
  - Only W's address is granted in a cycle; a requester on a different address waits, even if it would merge next cycle.
- Write coherence is out of scope. Register-file write-through is handled by the forwarding unit.

Decomposition:
- Package regfile_arb_pkg:
  - constants XZR_ADDR=5'd31, default NREQ/AW/DW.
  - a function onehot_to_idx for the winner index.
- Sub-module rr_pick:
  - parameterised NREQ.
  - inputs valid vector and ptr; outputs winner one-hot, winner index, any.
  - Implemented as a double-width masked priority scan.
- The top level holds the address compare/merge, pipeline registers and rr_ptr.

Test Plan:
- Reset then single read: req_valid=3'b001, addr 5 (mux_data=64'hDEAD_BEEF_0000_0005 when mux_sel==5) -> req_ready=001 same cycle, mux_sel=5 next cycle, rsp_valid=001 with rsp_data=0xDEAD_BEEF_0000_0005 at T+2 for one cycle.
- Round-robin: all three valid on addrs 1, 2, 3, held, data = 0x100+sel -> grants 001, 010, 100, 001 in consecutive cycles; responses 0x101, 0x102, 0x103 at T+2..T+4.
- Merge: req0 and req2 both addr 7, req1 addr 8 -> first grant 101; rsp_valid=101 with the same data; req1 is granted the next cycle.
- XZR: req1 addr 31, mux_data=all-ones -> rsp_data=0 when ZERO_R31=1; rsp_data=all-ones when rebuilt with ZERO_R31=0.
- en and reset:
  - Grant at T, then en=0 from T+1 -> response still at T+2; no grants while en=0; rr_ptr unchanged.
  - Separately, reset at T+1 -> no rsp_valid at T+2; outputs return to 0; the next grant starts from requester 0.
